// File: rtl/alu_exec_pipe_pkg.sv
// Shared types for the exec-unit ALU pipeline: opcode set and NZCV flag bundle.
package alu_exec_pipe_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    // Encodings 13..15 are unused and are reported as illegal by the ALU.
    typedef enum logic [3:0] {
        OpNot  = 4'd0,
        OpAnd  = 4'd1,
        OpOr   = 4'd2,
        OpXor  = 4'd3,
        OpAdd  = 4'd4,
        OpSub  = 4'd5,
        OpNand = 4'd6,
        OpNor  = 4'd7,
        OpXnor = 4'd8,
        OpRsh  = 4'd9,
        OpLsh  = 4'd10,
        OpRro  = 4'd11,
        OpLro  = 4'd12
    } enum_instr_exec_unit;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_barrel_shift.sv
// Combinational barrel shifter/rotator with carry-out of the last bit shifted out.
module alu_barrel_shift #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]         value_i,
    input  logic [$clog2(DATA_WIDTH)-1:0] amount_i,
    input  logic                          dir_left_i,
    input  logic                          rotate_i,
    output logic [DATA_WIDTH-1:0]         result_o,
    output logic                          carry_o
);

    localparam int unsigned ShW = $clog2(DATA_WIDTH);
    localparam logic [ShW:0] FullAmt = (ShW + 1)'(DATA_WIDTH);

    // One guard bit catches the last bit shifted out; it is 0 for amount 0.
    logic [DATA_WIDTH:0]   lsh_w;
    logic [DATA_WIDTH:0]   rsh_w;
    logic [ShW:0]          inv_amt_w;
    logic [DATA_WIDTH-1:0] lro_w;
    logic [DATA_WIDTH-1:0] rro_w;

    assign lsh_w     = {1'b0, value_i} << amount_i;
    assign rsh_w     = {value_i, 1'b0} >> amount_i;
    // Amount 0 gives a complementary shift of DATA_WIDTH, which yields 0.
    assign inv_amt_w = FullAmt - {1'b0, amount_i};
    assign lro_w     = (value_i << amount_i) | (value_i >> inv_amt_w);
    assign rro_w     = (value_i >> amount_i) | (value_i << inv_amt_w);

    // Select shift/rotate result and carry by direction and mode.
    always_comb begin
        result_o = '0;
        carry_o  = 1'b0;
        if (dir_left_i) begin
            result_o = rotate_i ? lro_w : lsh_w[DATA_WIDTH-1:0];
            carry_o  = !rotate_i && lsh_w[DATA_WIDTH];
        end else begin
            result_o = rotate_i ? rro_w : rsh_w[DATA_WIDTH:1];
            carry_o  = !rotate_i && rsh_w[0];
        end
    end

endmodule

// File: rtl/alu_exec_pipe.sv
// Exec-unit ALU: valid/ready input, combinational ALU, back-pressured result pipeline.
module alu_exec_pipe
    import alu_exec_pipe_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = WORD_WIDTH,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PIPE_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  enum_instr_exec_unit   in_opcode_i,
    input  logic [DATA_WIDTH-1:0] in_op0_i,
    input  logic [DATA_WIDTH-1:0] in_op1_i,
    input  logic [ADDR_WIDTH-1:0] in_addr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [3:0]            out_flags_o,
    output logic                  out_illegal_o,
    output logic                  busy_o
);

    localparam int unsigned ShW = $clog2(DATA_WIDTH);
    localparam int unsigned Msb = DATA_WIDTH - 1;

    // Payload width depends on module parameters, so the type lives here.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
        alu_flags_t            flags;
        logic                  illegal;
    } alu_stage_t;

    logic [DATA_WIDTH:0]   sum_w;
    logic [DATA_WIDTH:0]   diff_w;
    logic [DATA_WIDTH-1:0] sh_result_w;
    logic                  sh_carry_w;
    logic                  sh_left_w;
    logic                  sh_rotate_w;
    logic [DATA_WIDTH-1:0] res;
    logic                  carry;
    logic                  ovf;
    logic                  illegal;
    alu_stage_t            alu_res;

    assign sum_w       = {1'b0, in_op0_i} + {1'b0, in_op1_i};
    assign diff_w      = {1'b0, in_op0_i} + {1'b0, ~in_op1_i} + {{DATA_WIDTH{1'b0}}, 1'b1};
    assign sh_left_w   = (in_opcode_i == OpLsh) || (in_opcode_i == OpLro);
    assign sh_rotate_w = (in_opcode_i == OpRro) || (in_opcode_i == OpLro);

    alu_barrel_shift #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shift (
        .value_i    (in_op0_i),
        .amount_i   (in_op1_i[ShW-1:0]),
        .dir_left_i (sh_left_w),
        .rotate_i   (sh_rotate_w),
        .result_o   (sh_result_w),
        .carry_o    (sh_carry_w)
    );

    // Decode opcode into result, carry, overflow; illegal opcodes zero data and flags.
    always_comb begin
        res     = '0;
        carry   = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        unique case (in_opcode_i)
            OpNot:  res = ~in_op0_i;
            OpAnd:  res = in_op0_i & in_op1_i;
            OpOr:   res = in_op0_i | in_op1_i;
            OpXor:  res = in_op0_i ^ in_op1_i;
            OpNand: res = ~(in_op0_i & in_op1_i);
            OpNor:  res = ~(in_op0_i | in_op1_i);
            OpXnor: res = ~(in_op0_i ^ in_op1_i);
            OpAdd: begin
                res   = sum_w[Msb:0];
                carry = sum_w[DATA_WIDTH];
                ovf   = (in_op0_i[Msb] == in_op1_i[Msb]) && (res[Msb] != in_op0_i[Msb]);
            end
            OpSub: begin
                res   = diff_w[Msb:0];
                carry = diff_w[DATA_WIDTH];
                ovf   = (in_op0_i[Msb] != in_op1_i[Msb]) && (res[Msb] != in_op0_i[Msb]);
            end
            OpRsh, OpLsh, OpRro, OpLro: begin
                res   = sh_result_w;
                carry = sh_carry_w;
            end
            default: illegal = 1'b1;
        endcase
        alu_res.data    = illegal ? '0 : res;
        alu_res.addr    = in_addr_i;
        alu_res.flags.n = !illegal && res[Msb];
        alu_res.flags.z = !illegal && (res == '0);
        alu_res.flags.c = !illegal && carry;
        alu_res.flags.v = !illegal && ovf;
        alu_res.illegal = illegal;
    end

    logic [PIPE_STAGES-1:0] v_w;
    logic [PIPE_STAGES-1:0] adv;
    logic [PIPE_STAGES-1:0] load;
    alu_stage_t             stage_w [PIPE_STAGES];
    logic                   hole;

    // A stage drains when it is full and some stage below is empty or the output is taken.
    always_comb begin
        adv  = '0;
        hole = 1'b0;
        for (int i = 0; i < int'(PIPE_STAGES); i++) begin
            hole = 1'b0;
            for (int j = i + 1; j < int'(PIPE_STAGES); j++) begin
                hole = hole | !v_w[j];
            end
            adv[i] = v_w[i] && (hole || out_ready_i);
        end
    end

    assign in_ready_o = !flush_i && (!v_w[0] || adv[0]);

    // Stage 0 loads on accept; each later stage loads when its upstream drains.
    always_comb begin
        load    = '0;
        load[0] = in_valid_i && in_ready_o;
        for (int i = 1; i < int'(PIPE_STAGES); i++) begin
            load[i] = adv[i-1];
        end
    end

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        logic       v_d;
        logic       v_q;
        alu_stage_t s_in;
        alu_stage_t s_q;

        if (i == 0) begin : g_head
            assign s_in = alu_res;
        end else begin : g_body
            assign s_in = stage_w[i-1];
        end

        // Stage stays valid unless it drains; flush empties every stage.
        always_comb begin
            v_d = flush_i ? 1'b0 : (load[i] || (v_q && !adv[i]));
        end

        // Stage valid and payload registers.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                v_q <= 1'b0;
                s_q <= '0;
            end else begin
                v_q <= v_d;
                if (load[i]) begin
                    s_q <= s_in;
                end
            end
        end

        assign v_w[i]     = v_q;
        assign stage_w[i] = s_q;
    end

    assign out_valid_o   = v_w[PIPE_STAGES-1];
    assign out_data_o    = stage_w[PIPE_STAGES-1].data;
    assign out_addr_o    = stage_w[PIPE_STAGES-1].addr;
    assign out_flags_o   = stage_w[PIPE_STAGES-1].flags;
    assign out_illegal_o = stage_w[PIPE_STAGES-1].illegal;
    assign busy_o        = |v_w;

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Randomised and directed bench for alu_exec_pipe against a queue-based reference model.
module tb_alu_exec_pipe;
    import alu_exec_pipe_pkg::*;

    localparam int unsigned Dw         = 16;
    localparam int unsigned Aw         = 8;
    localparam int          PipeStages = 2;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                flush;
    logic                in_valid;
    logic                in_ready_o;
    enum_instr_exec_unit in_opcode;
    logic [Dw-1:0]       in_op0;
    logic [Dw-1:0]       in_op1;
    logic [Aw-1:0]       in_addr;
    logic                out_valid_o;
    logic                out_ready;
    logic [Dw-1:0]       out_data_o;
    logic [Aw-1:0]       out_addr_o;
    logic [3:0]          out_flags_o;
    logic                out_illegal_o;
    logic                busy_o;

    alu_exec_pipe #(
        .DATA_WIDTH  (Dw),
        .ADDR_WIDTH  (Aw),
        .PIPE_STAGES (PipeStages)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready_o),
        .in_opcode_i   (in_opcode),
        .in_op0_i      (in_op0),
        .in_op1_i      (in_op1),
        .in_addr_i     (in_addr),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data_o),
        .out_addr_o    (out_addr_o),
        .out_flags_o   (out_flags_o),
        .out_illegal_o (out_illegal_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    // Expected result straight from the opcode definitions, using 32-bit arithmetic.
    function automatic void ref_model(input int unsigned op, input int unsigned a,
                                      input int unsigned b, output int unsigned r,
                                      output int unsigned f, output bit ill);
        int unsigned amt = b % 16;
        int          sr;
        bit          c = 1'b0;
        bit          v = 1'b0;
        ill = 1'b0;
        r   = 0;
        case (op)
            0:  r = ~a;
            1:  r = a & b;
            2:  r = a | b;
            3:  r = a ^ b;
            4: begin
                r  = a + b;
                c  = (r > 32'hFFFF);
                sr = to_signed(a) + to_signed(b);
                v  = (sr > 32767) || (sr < -32768);
            end
            5: begin
                r  = a - b;
                c  = (a >= b);
                sr = to_signed(a) - to_signed(b);
                v  = (sr > 32767) || (sr < -32768);
            end
            6:  r = ~(a & b);
            7:  r = ~(a | b);
            8:  r = ~(a ^ b);
            9: begin
                r = a >> amt;
                c = (amt != 0) && (((a >> (amt - 1)) & 1) != 0);
            end
            10: begin
                r = a << amt;
                c = (amt != 0) && (((a >> (16 - amt)) & 1) != 0);
            end
            11: r = (a >> amt) | ((a << (16 - amt)) & 32'hFFFF);
            12: r = (a << amt) | (a >> (16 - amt));
            default: ill = 1'b1;
        endcase
        r = r & 32'hFFFF;
        if (ill) begin
            r = 0;
            f = 0;
        end else begin
            f = {28'd0, r[15], (r == 0), c, v};
        end
    endfunction

    typedef struct {
        int unsigned data;
        int unsigned addr;
        int unsigned flags;
        bit          ill;
        int          acc;
    } exp_t;

    exp_t        q[$];
    int unsigned delivered[$];
    bit          stall_prev = 1'b0;
    logic [Dw-1:0] prev_data;
    logic [Aw-1:0] prev_addr;
    logic [3:0]    prev_flags;

    // Scoreboard: an op becomes visible PipeStages-1 edges after accept, in order.
    always @(negedge clk) begin
        bit   vis;
        bit   rdy;
        exp_t e;
        if (reset_n && mon_en) begin
            vis = (q.size() > 0) && (cyc - q[0].acc >= PipeStages - 1);
            rdy = !flush && ((q.size() < PipeStages) || out_ready);
            check_eq("out_valid", out_valid_o, vis);
            check_eq("busy", busy_o, q.size() > 0);
            check_eq("in_ready", in_ready_o, rdy);
            if (stall_prev) begin
                check_eq("hold_data", out_data_o, prev_data);
                check_eq("hold_addr", out_addr_o, prev_addr);
                check_eq("hold_flags", out_flags_o, prev_flags);
            end
            if (vis) begin
                check_eq("out_data", out_data_o, q[0].data);
                check_eq("out_addr", out_addr_o, q[0].addr);
                check_eq("out_flags", out_flags_o, q[0].flags);
                check_eq("out_illegal", out_illegal_o, q[0].ill);
            end
            stall_prev = vis && !out_ready && !flush;
            prev_data  = out_data_o;
            prev_addr  = out_addr_o;
            prev_flags = out_flags_o;
            if (vis && out_ready && !flush) begin
                delivered.push_back(q[0].addr);
                void'(q.pop_front());
            end
            if (in_valid && rdy) begin
                ref_model(int'(in_opcode), in_op0, in_op1, e.data, e.flags, e.ill);
                e.addr = in_addr;
                e.acc  = cyc + 1;
                q.push_back(e);
            end
            if (flush) q.delete();
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op and hold it until accepted (bounded).
    task automatic send(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] tag);
        bit acc = 1'b0;
        in_valid  = 1'b1;
        in_opcode = enum_instr_exec_unit'(opc);
        in_op0    = a;
        in_op1    = b;
        in_addr   = tag;
        for (int k = 0; k < 60 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready_o;
            tick();
        end
        in_valid = 1'b0;
        check_eq("send_accept", acc, 1'b1);
    endtask

    // Single op with the output open; result must appear exactly two cycles after offer.
    task automatic run_vec(input logic [3:0] opc, input logic [15:0] a, input logic [15:0] b,
                           input logic [7:0] tag, input logic [15:0] exp_d,
                           input logic [3:0] exp_f, input logic exp_ill);
        out_ready = 1'b1;
        send(opc, a, b, tag);
        @(negedge clk);
        check_eq("vec_early", out_valid_o, 1'b0);
        tick();
        @(negedge clk);
        check_eq("vec_valid", out_valid_o, 1'b1);
        check_eq("vec_data", out_data_o, exp_d);
        check_eq("vec_flags", out_flags_o, exp_f);
        check_eq("vec_addr", out_addr_o, tag);
        check_eq("vec_illegal", out_illegal_o, exp_ill);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = OpAdd;
        in_op0    = '0;
        in_op1    = '0;
        in_addr   = '0;
        out_ready = 1'b1;
        #12;
        check_eq("rst_out_valid", out_valid_o, 1'b0);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_data", out_data_o, 16'h0);
        check_eq("rst_addr", out_addr_o, 8'h0);
        check_eq("rst_flags", out_flags_o, 4'h0);
        check_eq("rst_illegal", out_illegal_o, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 check_eq("rst_in_ready", in_ready_o, 1'b1);
        mon_en = 1'b1;

        // Arithmetic and shift vectors; flags are {N,Z,C,V}.
        run_vec(OpAdd, 16'hFFFF, 16'h0001, 8'h12, 16'h0000, 4'b0110, 1'b0);
        run_vec(OpSub, 16'h8000, 16'h0001, 8'h13, 16'h7FFF, 4'b0011, 1'b0);
        run_vec(OpSub, 16'h0000, 16'h0001, 8'h14, 16'hFFFF, 4'b1000, 1'b0);
        run_vec(OpRsh, 16'h0003, 16'h0001, 8'h15, 16'h0001, 4'b0010, 1'b0);
        run_vec(OpLsh, 16'h8001, 16'h0001, 8'h16, 16'h0002, 4'b0010, 1'b0);
        run_vec(OpLro, 16'h8001, 16'h0004, 8'h17, 16'h0018, 4'b0000, 1'b0);
        run_vec(OpRro, 16'h0001, 16'h0010, 8'h18, 16'h0001, 4'b0000, 1'b0);

        // Back-pressure: stall the output while five ADDs are offered back to back.
        delivered.delete();
        out_ready = 1'b0;
        fork
            begin
                for (int t = 1; t <= 5; t++) send(OpAdd, 16'($urandom), 16'($urandom), 8'(t));
            end
            begin
                repeat (2) tick();
                @(negedge clk);
                check_eq("bp_in_ready_low", in_ready_o, 1'b0);
                check_eq("bp_out_valid", out_valid_o, 1'b1);
                repeat (5) tick();
                out_ready = 1'b1;
            end
        join
        repeat (8) tick();
        check_eq("bp_count", delivered.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_order", (i < delivered.size()) ? delivered[i] : 0, i + 1);
        end

        // Flush with two ops in flight and a third offered.
        out_ready = 1'b0;
        send(OpAnd, 16'h00FF, 16'h0F0F, 8'h21);
        send(OpOr, 16'h00FF, 16'h0F0F, 8'h22);
        in_valid = 1'b1;
        in_opcode = OpXor;
        in_addr  = 8'h2F;
        flush    = 1'b1;
        @(negedge clk);
        check_eq("flush_in_ready", in_ready_o, 1'b0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("flush_out_valid", out_valid_o, 1'b0);
        check_eq("flush_busy", busy_o, 1'b0);
        tick();
        run_vec(OpXor, 16'h00F0, 16'h0FF0, 8'h23, 16'h0F00, 4'b0000, 1'b0);

        // Illegal opcode, then asynchronous reset in the middle of traffic.
        run_vec(4'd13, 16'h1234, 16'h5678, 8'h44, 16'h0000, 4'b0000, 1'b1);
        out_ready = 1'b0;
        send(OpAdd, 16'h0001, 16'h0002, 8'h51);
        send(OpSub, 16'h0005, 16'h0002, 8'h52);
        @(negedge clk);
        #2;
        mon_en  = 1'b0;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", out_valid_o, 1'b0);
        check_eq("mid_rst_busy", busy_o, 1'b0);
        check_eq("mid_rst_data", out_data_o, 16'h0);
        q.delete();
        @(posedge clk);
        #2 reset_n = 1'b1;
        #1 check_eq("mid_rst_in_ready", in_ready_o, 1'b1);
        tick();
        out_ready = 1'b1;
        mon_en    = 1'b1;

        // Random traffic with random stalls, occasional flushes and illegal opcodes.
        for (int n = 0; n < 400; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_opcode = enum_instr_exec_unit'(4'($urandom_range(0, 15)));
            in_op0    = 16'($urandom);
            in_op1    = 16'($urandom);
            in_addr   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check_eq("drain_empty", q.size(), 0);
        check_eq("drain_busy", busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
